// File: rtl/dab_sequencer_pkg.sv
// Shared types and constants for the DAB start-up/shutdown sequencer.
// Bus voltages are signed Q20.17; actuator commands are 9-bit signed.
package dab_pkg;
    localparam int BITS_INT  = 20;
    localparam int BITS_FRAC = 17;
    localparam int VW        = BITS_INT + BITS_FRAC + 1;
    localparam int TAU_W     = 9;
    localparam int LIM_W     = 8;
    localparam int CNT_W     = 16;
    localparam logic [LIM_W-1:0] LIM_MAX = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_SOFTSTART = 3'd2,
        ST_RUN       = 3'd3,
        ST_STOPPING  = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_VDC1    = 2'd1;
    localparam logic [1:0] FC_VDC2    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;
endpackage

// File: rtl/dab_sequencer_if.sv
// Controller/actuator-side bundle of the sequencer. There is no valid/ready
// handshake: trigger is a one-cycle period strobe and outputs are level signals.
interface dab_sequencer_if;
    import dab_pkg::*;

    logic                    CE;
    logic                    start;
    logic                    stop;
    logic                    clear;
    logic                    trigger;
    logic signed [VW-1:0]    Vdc1;
    logic signed [VW-1:0]    Vdc2;
    logic signed [TAU_W-1:0] tau1_cmd;
    logic signed [TAU_W-1:0] tau2_cmd;
    logic signed [TAU_W-1:0] phi_cmd;
    logic signed [TAU_W-1:0] tau1;
    logic signed [TAU_W-1:0] tau2;
    logic signed [TAU_W-1:0] phi;
    logic                    gate_en;
    logic [2:0]              state;
    logic                    fault;
    logic [1:0]              fault_code;

    modport master (
        output CE, start, stop, clear, trigger, Vdc1, Vdc2,
               tau1_cmd, tau2_cmd, phi_cmd,
        input  tau1, tau2, phi, gate_en, state, fault, fault_code
    );

    modport slave (
        input  CE, start, stop, clear, trigger, Vdc1, Vdc2,
               tau1_cmd, tau2_cmd, phi_cmd,
        output tau1, tau2, phi, gate_en, state, fault, fault_code
    );
endinterface

// File: rtl/dab_sym_clamp.sv
// Combinational symmetric clamp of a 9-bit signed command to [-lim, +lim].
// Comparison is done at 10 bits so cmd=-256 with lim=255 yields -255.
module dab_sym_clamp
    import dab_pkg::*;
(
    input  logic signed [TAU_W-1:0] cmd_i,
    input  logic [LIM_W-1:0]        lim_i,
    output logic signed [TAU_W-1:0] out_o
);
    logic signed [TAU_W:0] cmd_x;
    logic signed [TAU_W:0] pos_x;
    logic signed [TAU_W:0] neg_x;
    logic signed [TAU_W:0] res_x;

    assign cmd_x = {cmd_i[TAU_W-1], cmd_i};
    assign pos_x = {2'b00, lim_i};
    assign neg_x = -pos_x;

    always_comb begin
        res_x = cmd_x;
        if (cmd_x > pos_x)      res_x = pos_x;
        else if (cmd_x < neg_x) res_x = neg_x;
    end

    // Result lies in [-255, 255], so dropping the extra sign bit is lossless.
    assign out_o = res_x[TAU_W-1:0];
endmodule

// File: rtl/dab_sequencer.sv
// Start-up/shutdown sequencer between the DAB controller and PWM actuator:
// precharge check, soft-start ramp, run, controlled stop and voltage trips.
module dab_sequencer
    import dab_pkg::*;
#(
    parameter logic signed [VW-1:0] VIN_MIN  = 38'sd200 <<< BITS_FRAC,
    parameter logic signed [VW-1:0] VIN_MAX  = 38'sd450 <<< BITS_FRAC,
    parameter logic signed [VW-1:0] VOUT_MAX = 38'sd450 <<< BITS_FRAC,
    parameter int unsigned PRECHARGE_PERIODS = 100,
    parameter int unsigned TIMEOUT_PERIODS   = 10000,
    parameter int unsigned STEP              = 1
) (
    input  logic          clk,
    input  logic          rst,
    dab_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] PRE_N  = CNT_W'(PRECHARGE_PERIODS);
    localparam logic [CNT_W-1:0] TO_N   = CNT_W'(TIMEOUT_PERIODS);
    localparam logic [LIM_W-1:0] STEP_L = LIM_W'(STEP);

    state_t                  state_q;
    logic [LIM_W-1:0]        lim_q;
    logic [CNT_W-1:0]        ok_cnt_q;
    logic [CNT_W-1:0]        to_cnt_q;
    logic signed [TAU_W-1:0] tau1_q, tau2_q, phi_q;
    logic                    gate_en_q;
    logic                    fault_q;
    logic [1:0]              fault_code_q;

    logic [LIM_W:0]          lim_sum;
    logic [LIM_W-1:0]        lim_inc, lim_dec, lim_d;
    logic [CNT_W-1:0]        ok_cnt_d, to_cnt_d;
    logic signed [TAU_W-1:0] tau1_cl, tau2_cl, phi_cl;
    logic                    trip1, trip2, active, drop, outs_zero;

    assign lim_sum  = {1'b0, lim_q} + {1'b0, STEP_L};
    assign lim_inc  = lim_sum[LIM_W] ? LIM_MAX : lim_sum[LIM_W-1:0];
    assign lim_dec  = (lim_q > STEP_L) ? (lim_q - STEP_L) : '0;
    assign lim_d    = (state_q == ST_STOPPING) ? lim_dec : lim_inc;
    assign ok_cnt_d = (bus.Vdc1 >= VIN_MIN) ? (ok_cnt_q + 1'b1) : '0;
    assign to_cnt_d = to_cnt_q + 1'b1;

    assign trip1     = bus.Vdc1 > VIN_MAX;
    assign trip2     = bus.Vdc2 > VOUT_MAX;
    assign active    = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign drop      = bus.stop || !bus.start;
    assign outs_zero = (tau1_q == '0) && (tau2_q == '0) && (phi_q == '0);

    // Clamps always see the limit that this period will store.
    dab_sym_clamp u_clamp_tau1 (.cmd_i(bus.tau1_cmd), .lim_i(lim_d), .out_o(tau1_cl));
    dab_sym_clamp u_clamp_tau2 (.cmd_i(bus.tau2_cmd), .lim_i(lim_d), .out_o(tau2_cl));
    dab_sym_clamp u_clamp_phi  (.cmd_i(bus.phi_cmd),  .lim_i(lim_d), .out_o(phi_cl));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            lim_q        <= '0;
            ok_cnt_q     <= '0;
            to_cnt_q     <= '0;
            tau1_q       <= '0;
            tau2_q       <= '0;
            phi_q        <= '0;
            gate_en_q    <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else if (bus.CE) begin
            if (active && (trip1 || trip2)) begin
                // Trips act on any enabled cycle, without waiting for a period.
                state_q      <= ST_FAULT;
                fault_q      <= 1'b1;
                fault_code_q <= trip1 ? FC_VDC1 : FC_VDC2;
                gate_en_q    <= 1'b0;
                lim_q        <= '0;
                tau1_q       <= '0;
                tau2_q       <= '0;
                phi_q        <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            state_q  <= ST_PRECHARGE;
                            ok_cnt_q <= '0;
                            to_cnt_q <= '0;
                        end
                    end
                    ST_PRECHARGE: begin
                        if (drop) begin
                            state_q <= ST_IDLE;
                        end else if (bus.trigger) begin
                            ok_cnt_q <= ok_cnt_d;
                            to_cnt_q <= to_cnt_d;
                            if (ok_cnt_d == PRE_N) begin
                                state_q   <= ST_SOFTSTART;
                                lim_q     <= '0;
                                gate_en_q <= 1'b1;
                            end else if (to_cnt_d == TO_N) begin
                                state_q      <= ST_FAULT;
                                fault_q      <= 1'b1;
                                fault_code_q <= FC_TIMEOUT;
                            end
                        end
                    end
                    ST_SOFTSTART: begin
                        if (drop) begin
                            state_q <= ST_STOPPING;
                        end else if (bus.trigger) begin
                            if (lim_q == LIM_MAX) begin
                                state_q <= ST_RUN;
                                tau1_q  <= bus.tau1_cmd;
                                tau2_q  <= bus.tau2_cmd;
                                phi_q   <= bus.phi_cmd;
                            end else begin
                                lim_q  <= lim_d;
                                tau1_q <= tau1_cl;
                                tau2_q <= tau2_cl;
                                phi_q  <= phi_cl;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (drop) begin
                            state_q <= ST_STOPPING;
                        end else if (bus.trigger) begin
                            tau1_q <= bus.tau1_cmd;
                            tau2_q <= bus.tau2_cmd;
                            phi_q  <= bus.phi_cmd;
                        end
                    end
                    ST_STOPPING: begin
                        if (lim_q == '0 && outs_zero) begin
                            state_q   <= ST_IDLE;
                            gate_en_q <= 1'b0;
                        end else if (bus.trigger) begin
                            lim_q  <= lim_d;
                            tau1_q <= tau1_cl;
                            tau2_q <= tau2_cl;
                            phi_q  <= phi_cl;
                        end
                    end
                    ST_FAULT: begin
                        if (bus.clear && !bus.start) begin
                            state_q      <= ST_IDLE;
                            fault_q      <= 1'b0;
                            fault_code_q <= FC_NONE;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        gate_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tau1       = tau1_q;
    assign bus.tau2       = tau2_q;
    assign bus.phi        = phi_q;
    assign bus.gate_en    = gate_en_q;
    assign bus.state      = state_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;
endmodule

// File: tb/tb_dab_sequencer.sv
// Directed bench for dab_sequencer: start-up, ramp, stop, trips, timeout,
// clock-enable freeze and asynchronous reset, with hand-computed expectations.
module tb_dab_sequencer;
    localparam logic signed [37:0] V150 = 38'sd19660800;
    localparam logic signed [37:0] V300 = 38'sd39321600;
    localparam logic signed [37:0] V460 = 38'sd60293120;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    dab_sequencer_if bus ();

    dab_sequencer dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each posedge inside the window is one period; checks happen on negedges.
    task automatic periods(input int n);
        bus.trigger = 1'b1;
        repeat (n) @(negedge clk);
        bus.trigger = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input int t1, input int t2, input int ph);
        chk({tag, ".tau1"}, int'($signed(bus.tau1)), t1);
        chk({tag, ".tau2"}, int'($signed(bus.tau2)), t2);
        chk({tag, ".phi"},  int'($signed(bus.phi)),  ph);
    endtask

    task automatic to_run();
        bus.start = 1'b1;
        cyc(1);
        periods(100);
        periods(256);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        bus.CE = 1'b1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.clear = 1'b0;
        bus.trigger = 1'b0;
        bus.Vdc1 = V300;
        bus.Vdc2 = V300;
        bus.tau1_cmd = 9'sd100;
        bus.tau2_cmd = 9'sd80;
        bus.phi_cmd = -9'sd50;
        cyc(3);

        // Reset values
        chk("rst.state", int'(bus.state), 0);
        chk("rst.gate", int'(bus.gate_en), 0);
        chk("rst.fault", int'(bus.fault), 0);
        chk("rst.code", int'(bus.fault_code), 0);
        chk_outs("rst", 0, 0, 0);
        rst_n = 1'b1;
        cyc(1);
        chk("idle.hold", int'(bus.state), 0);

        // Nominal start-up
        bus.start = 1'b1;
        cyc(1);
        chk("pre.enter", int'(bus.state), 1);
        periods(99);
        chk("pre.99", int'(bus.state), 1);
        chk("pre.gate", int'(bus.gate_en), 0);
        periods(1);
        chk("ss.enter", int'(bus.state), 2);
        chk("ss.gate", int'(bus.gate_en), 1);
        chk_outs("ss.k0", 0, 0, 0);
        periods(1);
        chk_outs("ss.k1", 1, 1, -1);
        periods(59);
        chk_outs("ss.k60", 60, 60, -50);

        // Clock-enable freeze during soft-start
        bus.CE = 1'b0;
        periods(5);
        chk_outs("ce.frozen", 60, 60, -50);
        chk("ce.state", int'(bus.state), 2);
        bus.CE = 1'b1;
        periods(1);
        chk_outs("ce.k61", 61, 61, -50);
        periods(39);
        chk_outs("ss.k100", 100, 80, -50);
        periods(154);
        chk_outs("ss.k254", 100, 80, -50);
        bus.phi_cmd = -9'sd256;
        periods(1);
        chk("ss.k255.phi_m256", int'($signed(bus.phi)), -255);
        chk("ss.k255.state", int'(bus.state), 2);
        bus.phi_cmd = -9'sd50;
        periods(1);
        chk("run.enter", int'(bus.state), 3);
        chk("run.gate", int'(bus.gate_en), 1);
        chk_outs("run", 100, 80, -50);

        // Controlled stop
        bus.phi_cmd = -9'sd200;
        periods(1);
        chk("run.phi200", int'($signed(bus.phi)), -200);
        bus.stop = 1'b1;
        cyc(1);
        chk("stop.enter", int'(bus.state), 4);
        chk("stop.gate", int'(bus.gate_en), 1);
        periods(55);
        chk("stop.lim200", int'($signed(bus.phi)), -200);
        periods(1);
        chk("stop.lim199", int'($signed(bus.phi)), -199);
        chk("stop.tau1", int'($signed(bus.tau1)), 100);
        periods(199);
        chk_outs("stop.lim0", 0, 0, 0);
        chk("stop.still", int'(bus.state), 4);
        bus.start = 1'b0;
        cyc(1);
        chk("stop.idle", int'(bus.state), 0);
        chk("stop.gate_off", int'(bus.gate_en), 0);
        bus.stop = 1'b0;
        bus.phi_cmd = -9'sd50;

        // Vdc2 overvoltage in RUN, no trigger
        to_run();
        chk("ov2.run", int'(bus.state), 3);
        bus.Vdc2 = V460;
        cyc(1);
        chk("ov2.state", int'(bus.state), 5);
        chk("ov2.gate", int'(bus.gate_en), 0);
        chk("ov2.code", int'(bus.fault_code), 2);
        chk("ov2.fault", int'(bus.fault), 1);
        chk_outs("ov2", 0, 0, 0);
        bus.Vdc2 = V300;
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        chk("ov2.clear_ignored", int'(bus.state), 5);
        bus.start = 1'b0;
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        chk("ov2.cleared", int'(bus.state), 0);
        chk("ov2.fault0", int'(bus.fault), 0);
        chk("ov2.code0", int'(bus.fault_code), 0);

        // Both buses over: Vdc1 code wins
        to_run();
        chk("ov1.run", int'(bus.state), 3);
        bus.Vdc1 = V460;
        bus.Vdc2 = V460;
        cyc(1);
        chk("ov1.code", int'(bus.fault_code), 1);
        chk("ov1.gate", int'(bus.gate_en), 0);
        bus.Vdc1 = V300;
        bus.Vdc2 = V300;
        bus.start = 1'b0;
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        chk("ov1.cleared", int'(bus.state), 0);

        // Precharge timeout
        bus.Vdc1 = V150;
        bus.start = 1'b1;
        cyc(1);
        periods(9999);
        chk("to.9999", int'(bus.state), 1);
        periods(1);
        chk("to.state", int'(bus.state), 5);
        chk("to.code", int'(bus.fault_code), 3);
        chk("to.gate", int'(bus.gate_en), 0);
        chk("to.fault", int'(bus.fault), 1);
        chk_outs("to", 0, 0, 0);
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        chk("to.clear_ignored", int'(bus.state), 5);
        bus.start = 1'b0;
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        chk("to.cleared", int'(bus.state), 0);

        // Asynchronous reset between edges
        bus.Vdc1 = V300;
        to_run();
        chk("ar.run_gate", int'(bus.gate_en), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("ar.gate", int'(bus.gate_en), 0);
        chk("ar.state", int'(bus.state), 0);
        chk_outs("ar", 0, 0, 0);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        chk("ar.idle", int'(bus.state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/dab_sequencer.md
Name: dab_sequencer

Overview:
Start-up/shutdown sequencer placed between the converter controller (tau1/tau2/phi commands) and the DAB PWM actuator. Sequences IDLE -> precharge check -> soft-start ramp -> run -> controlled stop, supervises Vdc1/Vdc2 limits and gates the switch outputs via gate_en. It updates the actuator's tau1/tau2/phi only on the switching-period strobe, so each period uses a coherent set.

Parameters:
VIN_MIN, 38'sd(200<<17), minimum Vdc1 for precharge-OK, signed Q20.17
VIN_MAX, 38'sd(450<<17), Vdc1 overvoltage trip, signed Q20.17
VOUT_MAX, 38'sd(450<<17), Vdc2 overvoltage trip, signed Q20.17
PRECHARGE_PERIODS, 100, consecutive periods with Vdc1>=VIN_MIN required
TIMEOUT_PERIODS, 10000, precharge timeout in periods (16-bit counter)
STEP, 1, soft-start/stop limit increment per period (1..255)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-low reset
CE  in  1  clock enable; low freezes all state and outputs
start  in  1  level; request operation
stop  in  1  level; request controlled shutdown
clear  in  1  pulse; clear latched fault
trigger  in  1  one-cycle period strobe from actuator
Vdc1, Vdc2  in  38 each  signed Q20.17 bus voltages ([20:-17])
tau1_cmd, tau2_cmd, phi_cmd  in  9 each  signed commands from controller
tau1, tau2, phi  out  9 each  signed, registered, to actuator
gate_en  out  1  high = switches may toggle
state  out  3  current state encoding
fault  out  1  latched fault flag
fault_code  out  2  0 none, 1 Vdc1 over, 2 Vdc2 over, 3 precharge timeout

Behaviour:
- Reset (rst=0, async): state=IDLE, tau1=tau2=phi=0, gate_en=0, fault=0, fault_code=0, lim=0, counters=0.
- Nothing changes in a cycle where CE=0. "Period" means a cycle with CE=1 and trigger=1.
- States: IDLE(0), PRECHARGE(1), SOFTSTART(2), RUN(3), STOPPING(4), FAULT(5).
- IDLE: start=1 and stop=0 -> PRECHARGE, with ok_cnt=0 and to_cnt=0.
- PRECHARGE: each period, ok_cnt++ if Vdc1>=VIN_MIN, else ok_cnt=0; to_cnt++ every period.
  - ok_cnt reaches PRECHARGE_PERIODS -> SOFTSTART, lim=0.
  - to_cnt reaches TIMEOUT_PERIODS -> FAULT, code 3.
  - stop=1 or start=0 -> IDLE.
- SOFTSTART: each period, lim=min(lim+STEP,255) and outputs take the clamped commands (see below). The period after lim reaches 255 -> RUN.
- Clamp: each output = clamp(cmd, -lim, +lim). lim is 8-bit unsigned; compare against the sign-extended 10-bit value; cmd=-256 with lim=255 gives -255.
- RUN: each period, outputs = cmd unclamped.
- stop=1 or start=0 in SOFTSTART or RUN -> STOPPING, keeping the current lim (RUN enters with lim=255).
- STOPPING: each period, lim=max(lim-STEP,0) and outputs are clamped. When lim=0 and outputs=0 -> IDLE. start is ignored in STOPPING.
- gate_en = 1 in SOFTSTART, RUN and STOPPING; 0 otherwise. It is registered and changes in the same cycle as state.
- Outputs hold their values between periods. The new value is visible the cycle after the trigger cycle (latency 1).
- Voltage trips are checked every CE cycle, not only at periods:
  - In any state except IDLE and FAULT, Vdc1>VIN_MAX -> FAULT code 1; otherwise Vdc2>VOUT_MAX -> FAULT code 2 (code 1 wins if both).
- FAULT entry: next cycle gate_en=0, tau1=tau2=phi=0, fault=1. Entry does not wait for trigger.
- FAULT exit: clear=1 and start=0 in the same cycle -> IDLE with fault=0 and fault_code=0. clear while start=1 is ignored.
- Priority in one cycle: fault trip > stop/start-drop > progression.
- Mid-operation reset: immediate async return to reset values; gate_en drops without waiting for a period.

Decomposition:
- Package dab_pkg: state enum, fault code constants, Q-format widths (BITS_INT=20, BITS_FRAC=17), tau width 9, LIM_MAX=255.
- Sub-module dab_sym_clamp: combinational symmetric clamp (9-bit signed in, 8-bit lim in, 9-bit out), instantiated 3x.

Test Plan:
- Nominal start: Vdc1=300 V, start=1, cmds (100,80,-50), STEP=1 -> PRECHARGE for 100 periods, then SOFTSTART.
  - Period k: outputs = (min(100,k), min(80,k), max(-50,-k)).
  - RUN after 255 periods, outputs (100,80,-50), gate_en=1.
- Precharge timeout: Vdc1=150 V for 10000 periods -> FAULT code 3, gate_en=0, outputs 0.
  - clear with start=1 has no effect; start=0 plus clear -> IDLE.
- Overvoltage mid-cycle: in RUN, Vdc2=460 V with trigger=0 -> next cycle gate_en=0, fault_code=2, phi=0.
  - Vdc1=460 V in the same cycle -> code 1 instead.
- Controlled stop: RUN with phi_cmd=-200, stop=1 -> STOPPING; phi=-200 until lim drops below 200, then -lim each period; IDLE when lim=0, gate_en=0.
- CE gating: CE=0 with trigger pulses during SOFTSTART -> lim and outputs frozen; resumes on CE=1.
- Async reset: rst=0 mid-RUN between clock edges -> outputs zero and gate_en=0 immediately; state=IDLE.
